mem_store_ctrl: RTL and testbench
=================================

# mem_store_ctrl

Store-path controller for the RISC-V datapath: accepts one store request (sb/sh/sw/sd) from the control unit and writes it into the 32-bit-word data memory. The memory is of the Memoria32 type, with separate read/write addresses, 32-bit data and a single write strobe. Sub-word stores use a read-modify-write sequence, and doubleword stores are split into two word writes. The block sits between the control unit/datapath (store address from the ALU, store data from the register file) and the data memory instance.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept a request this cycle.
- req_addr  in  64  byte address; only [31:0] used.
- req_data  in  64  store data, right-aligned (sb uses [7:0], sh [15:0], sw [31:0], sd [63:0]).
- req_size  in  2  00 sb, 01 sh, 10 sw, 11 sd.
- mem_raddress  out  32  word-aligned memory read address.
- mem_waddress  out  32  word-aligned memory write address.
- mem_datain  out  32  write data to memory.
- mem_dataout  in  32  read data from memory; valid the cycle after mem_raddress is presented.
- mem_wr  out  1  memory write strobe.
- done  out  1  one-cycle pulse when the store has completed.
- misaligned  out  1  one-cycle pulse when a request was rejected for misalignment.

## Operation
- Handshake: a request is accepted on a rising edge with req_valid=1 and req_ready=1. On acceptance, the block captures addr[31:0], data and size. req_ready=1 only in IDLE.
- Alignment check at accept:
  - sh is misaligned if addr[0]≠0.
  - sw is misaligned if addr[1:0]≠0.
  - sd is misaligned if addr[2:0]≠0.
  - sb is always aligned.
- A misaligned request goes to ERR and causes no memory write.
- Aligned word address: A = {addr[31:2], 2'b00}. Little-endian: byte k = addr[1:0] occupies bits [8k+7:8k].
- States:
  - IDLE: outputs idle.
    - Accepted sw or sd → WR_LO.
    - Accepted sb or sh → RD.
    - Misaligned → ERR.
  - RD: mem_raddress=A, mem_wr=0 → MERGE.
  - MERGE: mem_wr=1, mem_waddress=A. mem_datain = mem_dataout with the addressed lane(s) replaced by the store data; all other bytes are unchanged. sh replaces bytes addr[1:0] and addr[1:0]+1. → DONE.
  - WR_LO: mem_wr=1, mem_waddress=A, mem_datain=data[31:0]. If sd → WR_HI, else → DONE.
  - WR_HI: mem_wr=1, mem_waddress=A+4 (mod 2^32), mem_datain=data[63:32] → DONE.
  - DONE: done=1 → IDLE.
  - ERR: misaligned=1 → IDLE.
- mem_wr is high only in MERGE, WR_LO and WR_HI.
- Output values when not in use:
  - mem_datain=0 when mem_wr=0.
  - mem_raddress=A (captured) outside IDLE, and 0 in IDLE.
  - mem_waddress=A outside WR_HI.
- req_addr[63:32] is ignored; address arithmetic wraps modulo 2^32.
- Input changes after acceptance have no effect until the next acceptance.

## Timing
- Reset:
  - While reset=0 at an edge, the next state is IDLE and the capture registers clear.
  - During the reset cycle all outputs are 0, including req_ready.
  - From the first cycle with reset=1: req_ready=1, and done, misaligned and mem_wr are 0.
- Latency, with acceptance at edge T:
  - sw: write cycle T+1, done in cycle T+2.
  - sd: writes in T+1 and T+2, done in T+3.
  - sb/sh: read in T+1, merged write in T+2, done in T+3.
  - Misaligned: misaligned=1 in T+1, req_ready=1 again in T+2.
- Back-to-back requests: the next request can be accepted at the edge ending the first IDLE cycle after DONE/ERR. Throughput is one store per 3 cycles (sw) or 4 cycles (sd/sb/sh).
- Reset mid-operation: the sequence aborts at that edge with no further mem_wr. Writes already performed are not undone. For sd, reset during WR_HI suppresses the high-word write.
- req_valid in a non-IDLE state is ignored (not queued).

## Test plan
- Reset release: hold reset=0 for 2 cycles, then release → req_ready=1, mem_wr=0, done=0 in the first cycle.
- sw, addr=0x100, data=0x...DEADBEEF → one write (mem_waddress=0x100, mem_datain=0xDEADBEEF) in T+1, done in T+2, no read issued.
- sd, addr=0xFFFF_FFF8, data=0x11223344_55667788 → writes 0x55667788@0xFFFFFFF8 then 0x11223344@0xFFFFFFFC, done in T+3.
- sb, addr=0x202, data=0xAB, memory word 0x200=0x12345678 → read 0x200 in T+1, write 0x12AB5678@0x200 in T+2, done in T+3. Also sh, addr=0x202, data=0xCAFE on the same word → 0xCAFE5678.
- Misaligned: sw addr=0x101, and sd addr=0x104 → misaligned pulse in T+1, no mem_wr, req_ready=1 in T+2.
- Reset asserted during WR_HI of an sd → only the low word is written, done never pulses, IDLE with req_ready=1 after reset release.

Source files
------------

// File: rtl/mem_store_ctrl.sv
// Store-path controller: writes sb/sh/sw/sd requests into a 32-bit word memory,
// using read-modify-write for sub-word stores and two word writes for sd.
module mem_store_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_data,
  input  logic [1:0]  req_size,
  output logic [31:0] mem_raddress,
  output logic [31:0] mem_waddress,
  output logic [31:0] mem_datain,
  input  logic [31:0] mem_dataout,
  output logic        mem_wr,
  output logic        done,
  output logic        misaligned
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MERGE,
    WR_LO,
    WR_HI,
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] addr_q;
  logic [63:0] data_q;
  logic [1:0]  size_q;
  logic [31:0] word_addr;
  logic [31:0] hi_addr;
  logic [31:0] merged;
  logic        misaligned_req;
  logic        accept;
  logic        unused_addr_hi;

  // Only the low 32 address bits reach the memory.
  assign unused_addr_hi = ^req_addr[63:32];

  assign word_addr = {addr_q[31:2], 2'b00};
  assign hi_addr   = word_addr + 32'd4;
  assign accept    = req_valid && req_ready;

  always_comb begin
    misaligned_req = 1'b0;
    case (req_size)
      2'b01:   misaligned_req = req_addr[0];
      2'b10:   misaligned_req = |req_addr[1:0];
      2'b11:   misaligned_req = |req_addr[2:0];
      default: misaligned_req = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      size_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q <= req_addr[31:0];
        data_q <= req_data;
        size_q <= req_size;
      end
    end
  end

  // Replace only the addressed byte/halfword lane of the word read back.
  always_comb begin
    merged = mem_dataout;
    if (size_q == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
  end

  // Outputs are forced low while reset is held so an in-flight write is cut off.
  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    mem_raddress = (state == IDLE) ? 32'd0 : word_addr;
    mem_waddress = word_addr;
    mem_datain   = 32'd0;
    mem_wr       = 1'b0;
    done         = 1'b0;
    misaligned   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned_req)
            state_next = ERR;
          else if (req_size[1])
            state_next = WR_LO;
          else
            state_next = RD;
        end
      end
      RD: state_next = MERGE;
      MERGE: begin
        mem_wr     = 1'b1;
        mem_datain = merged;
        state_next = DONE;
      end
      WR_LO: begin
        mem_wr     = 1'b1;
        mem_datain = data_q[31:0];
        state_next = (size_q == 2'b11) ? WR_HI : DONE;
      end
      WR_HI: begin
        mem_wr       = 1'b1;
        mem_waddress = hi_addr;
        mem_datain   = data_q[63:32];
        state_next   = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        misaligned = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!reset) begin
      req_ready    = 1'b0;
      mem_raddress = 32'd0;
      mem_waddress = 32'd0;
      mem_datain   = 32'd0;
      mem_wr       = 1'b0;
      done         = 1'b0;
      misaligned   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Scoreboard bench for mem_store_ctrl with a behavioural Memoria32-style memory;
// expected writes/pulses are queued with their cycle and popped by a monitor.
module tb_mem_store_ctrl;

  localparam int EV_WRITE = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_MISAL = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] mem_raddress;
  logic [31:0] mem_waddress;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout = '0;
  logic        mem_wr;
  logic        done;
  logic        misaligned;

  logic [31:0] mem_model [logic [31:0]];
  exp_t        sb_q [$];
  int          cyc = 0;
  int          tests = 0;
  int          failures = 0;

  mem_store_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_size     (req_size),
    .mem_raddress (mem_raddress),
    .mem_waddress (mem_waddress),
    .mem_datain   (mem_datain),
    .mem_dataout  (mem_dataout),
    .mem_wr       (mem_wr),
    .done         (done),
    .misaligned   (misaligned)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] readWord(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'd0;
  endfunction

  // Registered-read memory: data for mem_raddress appears the following cycle.
  always @(posedge clock) begin
    mem_dataout <= readWord(mem_raddress);
    if (mem_wr) mem_model[mem_waddress] = mem_datain;
  end

  // Monitor: every write strobe, done or misaligned pulse must match the queue head.
  always @(negedge clock) begin
    int   kind;
    exp_t e;
    if (reset && (mem_wr || done || misaligned)) begin
      kind = mem_wr ? EV_WRITE : (done ? EV_DONE : EV_MISAL);
      tests++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_event kind=%0d cyc=%0d addr=%h data=%h required=none",
                 kind, cyc, mem_waddress, mem_datain);
      end else begin
        e = sb_q.pop_front();
        if (e.kind != kind || e.cyc != cyc ||
            (kind == EV_WRITE && (e.addr != mem_waddress || e.data != mem_datain))) begin
          failures++;
          $display("[TB] FAIL event got kind=%0d cyc=%0d addr=%h data=%h required kind=%0d cyc=%0d addr=%h data=%h",
                   kind, cyc, mem_waddress, mem_datain, e.kind, e.cyc, e.addr, e.data);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int kind, input int c, input logic [31:0] a,
                         input logic [31:0] d);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Waits (bounded) for req_ready, presents one request and returns the accept cycle.
  task automatic applyStimulus(input logic [63:0] addr, input logic [63:0] data,
                               input logic [1:0] size, output int acc);
    int waited = 0;
    @(negedge clock);
    while (!req_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!req_ready) begin
      tests++;
      failures++;
      $display("[TB] FAIL accept_timeout got req_ready=0 required=1");
      acc = -100;
      return;
    end
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    req_size  = size;
    @(posedge clock);
    #1;
    acc       = cyc;
    req_valid = 1'b0;
    req_addr  = 64'h5555_5555_5555_5555;
    req_data  = 64'hF0F0_F0F0_F0F0_F0F0;
    req_size  = ~size;
  endtask

  task automatic storeSw(input logic [63:0] addr, input logic [63:0] data,
                         input logic [31:0] waddr);
    int acc;
    applyStimulus(addr, data, 2'b10, acc);
    pushExp(EV_WRITE, acc, waddr, data[31:0]);
    pushExp(EV_DONE, acc + 1, 32'd0, 32'd0);
  endtask

  task automatic storeSd(input logic [63:0] addr, input logic [63:0] data,
                         input logic [31:0] waddr);
    int acc;
    applyStimulus(addr, data, 2'b11, acc);
    pushExp(EV_WRITE, acc, waddr, data[31:0]);
    pushExp(EV_WRITE, acc + 1, waddr + 32'd4, data[63:32]);
    pushExp(EV_DONE, acc + 2, 32'd0, 32'd0);
  endtask

  task automatic storeSub(input logic [63:0] addr, input logic [63:0] data,
                          input logic [1:0] size, input logic [31:0] waddr,
                          input logic [31:0] merged);
    int acc;
    applyStimulus(addr, data, size, acc);
    pushExp(EV_WRITE, acc + 1, waddr, merged);
    pushExp(EV_DONE, acc + 2, 32'd0, 32'd0);
  endtask

  task automatic storeBad(input logic [63:0] addr, input logic [1:0] size);
    int acc;
    applyStimulus(addr, 64'h0123_4567_89AB_CDEF, size, acc);
    pushExp(EV_MISAL, acc, 32'd0, 32'd0);
    @(negedge clock);
    @(negedge clock);
    checkOutput("ready_after_misaligned", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got=running required=finished");
    $display("[TB] %0d tests run, %0d failed", tests, failures + 1);
    $fatal(1);
  end

  initial begin
    int acc;
    mem_model[32'h200] = 32'h1234_5678;
    mem_model[32'h400] = 32'hAABB_CCDD;
    mem_model[32'h304] = 32'h0BAD_F00D;

    // Reset held for two cycles: everything low, then idle with ready.
    @(negedge clock);
    checkOutput("reset_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("reset_wr", {31'd0, mem_wr}, 32'd0);
    checkOutput("reset_raddr", mem_raddress, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checkOutput("release_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("release_wr", {31'd0, mem_wr}, 32'd0);
    checkOutput("release_done", {31'd0, done}, 32'd0);
    checkOutput("release_misal", {31'd0, misaligned}, 32'd0);
    checkOutput("idle_datain", mem_datain, 32'd0);

    storeSw(64'h0000_0000_0000_0100, 64'h0000_0000_DEAD_BEEF, 32'h0000_0100);
    storeSd(64'h0000_0000_FFFF_FFF8, 64'h1122_3344_5566_7788, 32'hFFFF_FFF8);
    storeSub(64'h202, 64'h0000_0000_0000_00AB, 2'b00, 32'h200, 32'h12AB_5678);
    storeSub(64'h202, 64'h0000_0000_0000_CAFE, 2'b01, 32'h200, 32'hCAFE_5678);
    storeSub(64'h201, 64'h0000_0000_0000_005A, 2'b00, 32'h200, 32'hCAFE_5A78);
    storeSub(64'h200, 64'h0000_0000_0000_1234, 2'b01, 32'h200, 32'hCAFE_1234);
    storeSub(64'h403, 64'h0000_0000_0000_0099, 2'b00, 32'h400, 32'h99BB_CCDD);
    storeSub(64'h400, 64'hFFFF_FFFF_FFFF_FFEE, 2'b00, 32'h400, 32'h99BB_CCEE);
    storeSw(64'hFFFF_FFFF_0000_0108, 64'h1234_5678_CAFE_F00D, 32'h0000_0108);

    storeBad(64'h101, 2'b10);
    storeBad(64'h104, 2'b11);
    storeBad(64'h201, 2'b01);

    // Reset lands during the high-word write of an sd: only the low word sticks.
    applyStimulus(64'h300, 64'h7777_6666_5555_4444, 2'b11, acc);
    pushExp(EV_WRITE, acc, 32'h300, 32'h5555_4444);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("abort_wr", {31'd0, mem_wr}, 32'd0);
    checkOutput("abort_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checkOutput("abort_release_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("abort_release_done", {31'd0, done}, 32'd0);
    checkOutput("abort_hi_word", readWord(32'h304), 32'h0BAD_F00D);
    checkOutput("abort_lo_word", readWord(32'h300), 32'h5555_4444);

    repeat (6) @(negedge clock);
    checkOutput("scoreboard_empty", sb_q.size(), 32'd0);
    checkOutput("final_sd_hi", readWord(32'hFFFF_FFFC), 32'h1122_3344);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
